// File: rtl/data_memory_bank.sv
// Word-addressed RAM bank with a valid/ready request port, byte-strobe writes,
// registered read responses, out-of-range error flag and a hardware clear sequencer.
module data_memory_bank #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 48,
    parameter int DEPTH  = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept_p0;
    logic               in_range_p0;
    logic [IDX_W-1:0]   idx_p0;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]   cur,
        input logic [DATA_W-1:0]   wdata,
        input logic [DATA_W/8-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Request decode: the full address must fall inside the array, not just its index bits.
    assign accept_p0   = req_valid && req_ready;
    assign idx_p0      = req_addr[IDX_W-1:0];
    assign in_range_p0 = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));

    // Control FSM and response stage; req_ready is high exactly when state is IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == IDX_W'(DEPTH-1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase

            rsp_valid <= accept_p0;
            rsp_err   <= accept_p0 && !in_range_p0;
            if (accept_p0) begin
                rsp_rdata <= (!req_write && in_range_p0) ? mem[idx_p0] : '0;
            end
        end
    end

    // Array port: clear writes and request writes never coincide since requests need IDLE.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept_p0 && req_write && in_range_p0) begin
            mem[idx_p0] <= merge_bytes(mem[idx_p0], req_wdata, req_wstrb);
        end
    end

endmodule
